// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and feeds the IF/ID register (ir, pc_out, valid) through a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00001000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] pc_out,
  output logic        valid
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] SKID    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] disc_addr;
  logic [31:0] skid_ir_p1;
  logic [31:0] skid_pc_p1;
  logic        xfer;
  logic        consume;

  // In DISCARD the old request stays on the bus while pc already holds the redirect target.
  assign imem_req  = !reset && (state != SKID);
  assign imem_addr = (state == DISCARD) ? disc_addr : pc;
  assign xfer      = imem_req && imem_ready;
  assign consume   = valid && !stall;
  assign pc_inc    = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      state  <= FETCH;
      valid  <= 1'b0;
      ir     <= NOP_INSTR;
      pc_out <= '0;
    end else if (redirect) begin
      valid <= 1'b0;
      ir    <= NOP_INSTR;
      pc    <= redirect_pc & ~32'd3;
      state <= (state != SKID && !imem_ready) ? DISCARD : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            pc <= pc_inc;
            if (!valid || consume) begin
              ir     <= imem_data;
              pc_out <= pc;
              valid  <= 1'b1;
            end else begin
              state <= SKID;
            end
          end else if (consume) begin
            valid <= 1'b0;
            ir    <= NOP_INSTR;
          end
        end
        SKID: begin
          if (consume) begin
            ir     <= skid_ir_p1;
            pc_out <= skid_pc_p1;
            state  <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath-only registers: no reset, only meaningful while the matching state is active.
  always_ff @(posedge clk) begin
    if (!reset && !redirect && state == FETCH && xfer && valid && stall) begin
      skid_ir_p1 <= imem_data;
      skid_pc_p1 <= pc;
    end
    if (!reset && redirect && state == FETCH) begin
      disc_addr <= pc;
    end
  end

endmodule
